// File: rtl/sy_ppl_bht_upd_queue.sv
// Staging queue between branch resolution and retire. Resolved branches are
// pushed in execution order, retire pops them one per committed branch, and
// the popped entry is presented as a registered BHT update one cycle later.
// Wrong-path entries are discarded by a flush and never reach the BHT.

package sy_ppl_bht_pkg;

    // Width of a branch pc
    localparam int unsigned AWTH = 32;

    // Update record handed to the branch history table
    typedef struct packed {
        logic            vld;
        logic [AWTH-1:0] pc;
        logic            taken;
    } bht_update_t;

endpackage

module sy_ppl_bht_upd_queue
    import sy_ppl_bht_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned PTR_WTH = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               res_vld_i,
    output logic               res_rdy_o,
    input  logic [AWTH-1:0]    res_pc_i,
    input  logic               res_taken_i,
    input  logic               res_is_cond_i,
    input  logic               commit_i,
    output bht_update_t        bht_update_o,
    output logic [PTR_WTH:0]   cnt_o,
    output logic               err_o
);

    // Pointers carry one wrap bit above the index so full and empty differ
    typedef logic [PTR_WTH:0] ptr_t;

    typedef struct packed {
        logic [AWTH-1:0] pc;
        logic            taken;
        logic            is_cond;
    } entry_t;

    entry_t      entries_q [DEPTH];
    entry_t      entries_d [DEPTH];
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    bht_update_t upd_q, upd_d;
    logic        err_q, err_d;

    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    ptr_t        rd_ptr_inc;
    entry_t      head;

    // Status, handshake and next-state computation for pointers, storage and outputs
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PTR_WTH-1:0] == rd_ptr_q[PTR_WTH-1:0]) &&
                (wr_ptr_q[PTR_WTH] != rd_ptr_q[PTR_WTH]);

        // A flush drops the incoming push; a full queue refuses it even if
        // the head leaves this same cycle
        push = res_vld_i && !full && !flush_i;
        pop  = commit_i && !empty;
        head = entries_q[rd_ptr_q[PTR_WTH-1:0]];

        entries_d = entries_q;
        if (push) begin
            entries_d[wr_ptr_q[PTR_WTH-1:0]] = '{pc:      res_pc_i,
                                                 taken:   res_taken_i,
                                                 is_cond: res_is_cond_i};
        end

        wr_ptr_d   = wr_ptr_q + ptr_t'(push);
        rd_ptr_inc = rd_ptr_q + ptr_t'(pop);
        // The commit in a flush cycle still retires the head; everything
        // younger is discarded by snapping the read pointer to the write pointer
        rd_ptr_d   = flush_i ? wr_ptr_q : rd_ptr_inc;

        // Unconditional branches pop normally but do not train the BHT
        upd_d     = upd_q;
        upd_d.vld = 1'b0;
        if (pop) begin
            upd_d.vld   = head.is_cond;
            upd_d.pc    = head.pc;
            upd_d.taken = head.taken;
        end

        err_d = err_q || (commit_i && empty);
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            upd_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
        end
    end

    // Entry payloads are plain storage and are not reset
    always_ff @(posedge clk_i) begin
        entries_q <= entries_d;
    end

    assign res_rdy_o    = !full;
    assign cnt_o        = wr_ptr_q - rd_ptr_q;
    assign bht_update_o = upd_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_sy_ppl_bht_upd_queue.sv
// Directed bench for the BHT update staging queue: push/commit ordering,
// one-cycle update latency, full back-pressure, flush and the sticky error.

module tb_sy_ppl_bht_upd_queue;
    import sy_ppl_bht_pkg::*;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              flush_i = 1'b0;
    logic              res_vld_i = 1'b0;
    logic              res_rdy_o;
    logic [AWTH-1:0]   res_pc_i = '0;
    logic              res_taken_i = 1'b0;
    logic              res_is_cond_i = 1'b0;
    logic              commit_i = 1'b0;
    bht_update_t       bht_update_o;
    logic [3:0]        cnt_o;
    logic              err_o;

    int errors = 0;
    int checks = 0;

    sy_ppl_bht_upd_queue #(.DEPTH(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .res_vld_i     (res_vld_i),
        .res_rdy_o     (res_rdy_o),
        .res_pc_i      (res_pc_i),
        .res_taken_i   (res_taken_i),
        .res_is_cond_i (res_is_cond_i),
        .commit_i      (commit_i),
        .bht_update_o  (bht_update_o),
        .cnt_o         (cnt_o),
        .err_o         (err_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Drive one cycle of inputs, take the edge, and settle 1 time unit after it
    task automatic applyStimulus(input logic vld, input logic [AWTH-1:0] pc,
                                 input logic taken, input logic cond,
                                 input logic commit, input logic flush,
                                 input logic rst);
        res_vld_i     = vld;
        res_pc_i      = pc;
        res_taken_i   = taken;
        res_is_cond_i = cond;
        commit_i      = commit;
        flush_i       = flush;
        rst_i         = rst;
        @(posedge clk);
        #1;
        res_vld_i = 1'b0;
        commit_i  = 1'b0;
        flush_i   = 1'b0;
        rst_i     = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [AWTH-1:0] pc, input logic taken, input logic cond);
        applyStimulus(1'b1, pc, taken, cond, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic commit();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic reset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Directed test sequence
    initial begin
        logic [AWTH-1:0] pc;

        reset();
        reset();
        $display("[TB] reset state");
        checkOutput("rst_cnt", 64'(cnt_o), 64'd0);
        checkOutput("rst_rdy", 64'(res_rdy_o), 64'd1);
        checkOutput("rst_upd", 64'(bht_update_o), 64'd0);
        checkOutput("rst_err", 64'(err_o), 64'd0);

        $display("[TB] single conditional branch");
        push(32'h100, 1'b1, 1'b1);
        checkOutput("t1_cnt_push", 64'(cnt_o), 64'd1);
        checkOutput("t1_vld_before", 64'(bht_update_o.vld), 64'd0);
        commit();
        checkOutput("t1_cnt_pop", 64'(cnt_o), 64'd0);
        checkOutput("t1_vld", 64'(bht_update_o.vld), 64'd1);
        checkOutput("t1_pc", 64'(bht_update_o.pc), 64'h100);
        checkOutput("t1_taken", 64'(bht_update_o.taken), 64'd1);
        idle();
        checkOutput("t1_vld_drop", 64'(bht_update_o.vld), 64'd0);

        $display("[TB] unconditional branch");
        push(32'h200, 1'b1, 1'b0);
        checkOutput("t2_cnt_push", 64'(cnt_o), 64'd1);
        commit();
        checkOutput("t2_vld", 64'(bht_update_o.vld), 64'd0);
        checkOutput("t2_cnt_pop", 64'(cnt_o), 64'd0);
        checkOutput("t2_err", 64'(err_o), 64'd0);

        $display("[TB] fill, back-pressure and drain");
        for (int i = 0; i < 8; i++) begin
            push(32'h300 + 32'(4 * i), 1'(i % 2), 1'b1);
        end
        checkOutput("t3_cnt_full", 64'(cnt_o), 64'd8);
        checkOutput("t3_rdy_full", 64'(res_rdy_o), 64'd0);
        applyStimulus(1'b1, 32'h320, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_cnt_refused", 64'(cnt_o), 64'd7);
        checkOutput("t3_rdy_after", 64'(res_rdy_o), 64'd1);
        checkOutput("t3_head_vld", 64'(bht_update_o.vld), 64'd1);
        checkOutput("t3_head_pc", 64'(bht_update_o.pc), 64'h300);
        checkOutput("t3_head_taken", 64'(bht_update_o.taken), 64'd0);
        push(32'h320, 1'b1, 1'b1);
        checkOutput("t3_cnt_refill", 64'(cnt_o), 64'd8);
        for (int k = 0; k < 8; k++) begin
            commit();
            checkOutput($sformatf("t3_drain_pc%0d", k), 64'(bht_update_o.pc),
                        64'h304 + 64'(4 * k));
            checkOutput($sformatf("t3_drain_tk%0d", k), 64'(bht_update_o.taken),
                        (k == 7) ? 64'd1 : 64'((k + 1) % 2));
            checkOutput($sformatf("t3_drain_vld%0d", k), 64'(bht_update_o.vld), 64'd1);
        end
        checkOutput("t3_cnt_empty", 64'(cnt_o), 64'd0);

        $display("[TB] flush with commit and push");
        push(32'h400, 1'b1, 1'b1);
        push(32'h404, 1'b0, 1'b1);
        push(32'h408, 1'b1, 1'b1);
        checkOutput("t4_cnt_pre", 64'(cnt_o), 64'd3);
        applyStimulus(1'b1, 32'h40C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_vld", 64'(bht_update_o.vld), 64'd1);
        checkOutput("t4_pc", 64'(bht_update_o.pc), 64'h400);
        checkOutput("t4_cnt", 64'(cnt_o), 64'd0);
        checkOutput("t4_err_pre", 64'(err_o), 64'd0);
        idle();
        commit();
        checkOutput("t4_err_set", 64'(err_o), 64'd1);
        checkOutput("t4_empty_vld", 64'(bht_update_o.vld), 64'd0);
        checkOutput("t4_empty_cnt", 64'(cnt_o), 64'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_err_flush", 64'(err_o), 64'd1);

        $display("[TB] back-to-back pairs across wrap");
        reset();
        checkOutput("t5_err_rst", 64'(err_o), 64'd0);
        push(32'h0, 1'b0, 1'b1);
        for (int i = 1; i < 20; i++) begin
            applyStimulus(1'b1, 32'(4 * i), 1'(i % 2), 1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("t5_pc%0d", i - 1), 64'(bht_update_o.pc), 64'(4 * (i - 1)));
            checkOutput($sformatf("t5_tk%0d", i - 1), 64'(bht_update_o.taken), 64'((i - 1) % 2));
            checkOutput($sformatf("t5_cnt%0d", i - 1), 64'(cnt_o), 64'd1);
        end
        commit();
        checkOutput("t5_pc19", 64'(bht_update_o.pc), 64'h4C);
        checkOutput("t5_vld19", 64'(bht_update_o.vld), 64'd1);
        checkOutput("t5_cnt_end", 64'(cnt_o), 64'd0);
        checkOutput("t5_err", 64'(err_o), 64'd0);

        $display("[TB] reset with entries queued");
        commit();
        checkOutput("t6_err_pre", 64'(err_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            pc = 32'h600 + 32'(4 * i);
            push(pc, 1'b1, 1'b1);
        end
        checkOutput("t6_cnt_pre", 64'(cnt_o), 64'd4);
        reset();
        checkOutput("t6_cnt", 64'(cnt_o), 64'd0);
        checkOutput("t6_rdy", 64'(res_rdy_o), 64'd1);
        checkOutput("t6_upd", 64'(bht_update_o), 64'd0);
        checkOutput("t6_err", 64'(err_o), 64'd0);
        commit();
        checkOutput("t6_err_commit", 64'(err_o), 64'd1);
        checkOutput("t6_vld_commit", 64'(bht_update_o.vld), 64'd0);

        $display("[TB] push on empty with same-cycle commit");
        reset();
        applyStimulus(1'b1, 32'h500, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t7_cnt", 64'(cnt_o), 64'd1);
        checkOutput("t7_err", 64'(err_o), 64'd1);
        checkOutput("t7_vld", 64'(bht_update_o.vld), 64'd0);
        commit();
        checkOutput("t7_pc", 64'(bht_update_o.pc), 64'h500);
        checkOutput("t7_vld_pop", 64'(bht_update_o.vld), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
